// File: rtl/mod_ref_feeder.sv
// mod_ref_feeder: packs serial modulation bits into 32-bit condition words
// and presents them with a reference operand and its two's-complement negation.
module mod_ref_feeder #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    output logic        bit_ready,
    input  logic        flush,
    input  logic [31:0] ref_in,
    input  logic        ref_load,
    output logic [31:0] input_bit,
    output logic [31:0] array_ref_wire_1,
    output logic [31:0] array_ref_m_wire_1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] word_cnt
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  fill;
    logic [4:0]  pos;
    logic [31:0] sreg;
    logic [31:0] sreg_nxt;
    logic [31:0] ref_q;
    logic [31:0] pend;
    logic        pend_vld;
    logic        live;
    logic        accept;
    logic        fire;
    logic        done;

    assign bit_ready = live && (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = bit_valid && bit_ready;
    assign fire      = out_valid && out_ready;
    assign done      = (state == SHIFT) && ((accept && fill == 5'd31) || flush);
    assign pos       = MSB_FIRST ? (5'd31 - fill) : fill;

    assign array_ref_m_wire_1 = 32'd0 - array_ref_wire_1;

    // sreg is cleared at word hand-off, so unfilled positions are already zero
    always_comb begin
        sreg_nxt = sreg;
        if (accept) sreg_nxt[pos] = bit_in;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (done) state_nxt = HOLD;
            HOLD:    if (fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live             <= 1'b0;
            fill             <= '0;
            sreg             <= '0;
            ref_q            <= '0;
            pend             <= '0;
            pend_vld         <= 1'b0;
            word_cnt         <= '0;
            input_bit        <= '0;
            array_ref_wire_1 <= '0;
        end else begin
            live <= 1'b1;
            if (accept) fill <= fill + 5'd1;
            if (done) begin
                input_bit        <= sreg_nxt;
                sreg             <= '0;
                array_ref_wire_1 <= ref_load ? ref_in : ref_q;
            end else begin
                sreg <= sreg_nxt;
            end
            // loads arriving while a word is presented wait for its hand-off
            if (fire) begin
                fill     <= '0;
                word_cnt <= word_cnt + 16'd1;
                pend_vld <= 1'b0;
                if (ref_load)      ref_q <= ref_in;
                else if (pend_vld) ref_q <= pend;
            end else if (ref_load) begin
                if (out_valid) begin
                    pend     <= ref_in;
                    pend_vld <= 1'b1;
                end else begin
                    ref_q <= ref_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_ref_feeder.sv
// Bench for mod_ref_feeder: table of words driven into MSB-first and
// LSB-first instances, expected triples queued and compared at hand-off.
module tb_mod_ref_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        flush = 1'b0;
    logic        ref_load = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] ref_in = '0;
    logic [31:0] ib0, ar0, am0, ib1, ar1, am1;
    logic        rdy0, rdy1, ov0, ov1;
    logic [15:0] wc0, wc1;
    logic [15:0] m_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mod_ref_feeder #(.MSB_FIRST(1'b1)) u0 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(rdy0), .flush(flush), .ref_in(ref_in), .ref_load(ref_load),
        .input_bit(ib0), .array_ref_wire_1(ar0), .array_ref_m_wire_1(am0),
        .out_valid(ov0), .out_ready(out_ready), .word_cnt(wc0)
    );

    mod_ref_feeder #(.MSB_FIRST(1'b0)) u1 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(rdy1), .flush(flush), .ref_in(ref_in), .ref_load(ref_load),
        .input_bit(ib1), .array_ref_wire_1(ar1), .array_ref_m_wire_1(am1),
        .out_valid(ov1), .out_ready(out_ready), .word_cnt(wc1)
    );

    typedef struct {
        logic [31:0] seq;
        int          nbits;
        int          fmode;
        int          ldmode;
        logic [31:0] ldval;
        bit          dld;
        logic [31:0] dval;
        int          stall;
        logic [31:0] e_msb;
        logic [31:0] e_lsb;
        logic [31:0] e_ref;
        logic [31:0] e_refm;
    } vec_t;

    typedef struct {
        logic [31:0] msb;
        logic [31:0] lsb;
        logic [31:0] rf;
        logic [31:0] rfm;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[6];
    vec_t wv;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fl, input logic ld, input logic [31:0] ldv);
        int n;
        n = 0;
        bit_in = b;
        bit_valid = 1'b1;
        flush = fl;
        ref_load = ld;
        ref_in = ldv;
        while (!rdy0 && n < 40) begin
            tick();
            n++;
        end
        check("bit_ready_wait", {31'b0, rdy0}, 32'd1);
        tick();
        bit_valid = 1'b0;
        flush = 1'b0;
        ref_load = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit last;
        sbq.push_back('{v.e_msb, v.e_lsb, v.e_ref, v.e_refm});
        if (v.ldmode == 1) begin
            ref_load = 1'b1;
            ref_in = v.ldval;
            tick();
            ref_load = 1'b0;
        end
        for (int i = 0; i < v.nbits; i++) begin
            last = (i == v.nbits - 1);
            send_bit(v.seq[i], last && v.fmode == 1, last && v.ldmode == 2, v.ldval);
        end
        if (v.fmode == 2) begin
            check("pre_flush_valid", {31'b0, ov0}, 32'd0);
            flush = 1'b1;
            tick();
            flush = 1'b0;
        end
    endtask

    task automatic drain(input vec_t v);
        exp_t e;
        check("out_valid_latency", {31'b0, ov0}, 32'd1);
        check("u1_out_valid", {31'b0, ov1}, 32'd1);
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            e = '{32'h0, 32'h0, 32'h0, 32'h0};
        end else begin
            e = sbq.pop_front();
        end
        check("word_msb", ib0, e.msb);
        check("word_lsb", ib1, e.lsb);
        check("ref", ar0, e.rf);
        check("ref_neg", am0, e.rfm);
        for (int c = 0; c < v.stall; c++) begin
            if (c == 0 && v.dld) begin
                ref_load = 1'b1;
                ref_in = v.dval;
            end
            bit_valid = c[0];
            bit_in = 1'b1;
            flush = c[0];
            tick();
            ref_load = 1'b0;
            bit_valid = 1'b0;
            flush = 1'b0;
            check("stall_word", ib0, e.msb);
            check("stall_ref", ar0, e.rf);
            check("stall_ref_neg", am0, e.rfm);
            check("stall_valid", {31'b0, ov0}, 32'd1);
            check("stall_ready", {31'b0, rdy0}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        m_cnt = m_cnt + 16'd1;
        check("word_cnt", {16'b0, wc0}, {16'b0, m_cnt});
        check("word_cnt_u1", {16'b0, wc1}, {16'b0, m_cnt});
        check("post_valid", {31'b0, ov0}, 32'd0);
        check("post_ready", {31'b0, rdy0}, 32'd1);
        check("post_word_hold", ib0, e.msb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h55555555, 32, 0, 1, 32'h5, 1'b0, 32'h0, 10,
                   32'hAAAAAAAA, 32'h55555555, 32'h00000005, 32'hFFFFFFFB};
        tbl[1] = '{32'h0000000B, 4, 2, 0, 32'h0, 1'b0, 32'h0, 0,
                   32'hD0000000, 32'h0000000B, 32'h00000005, 32'hFFFFFFFB};
        tbl[2] = '{32'h00000005, 3, 1, 1, 32'h80000000, 1'b0, 32'h0, 1,
                   32'hA0000000, 32'h00000005, 32'h80000000, 32'h80000000};
        tbl[3] = '{32'hFFFF0000, 32, 1, 2, 32'h7, 1'b0, 32'h0, 0,
                   32'h0000FFFF, 32'hFFFF0000, 32'h00000007, 32'hFFFFFFF9};
        tbl[4] = '{32'h00000001, 32, 0, 1, 32'h1, 1'b1, 32'h80000000, 3,
                   32'h80000000, 32'h00000001, 32'h00000001, 32'hFFFFFFFF};
        tbl[5] = '{32'h12345678, 32, 0, 0, 32'h0, 1'b0, 32'h0, 0,
                   32'h1E6A2C48, 32'h12345678, 32'h80000000, 32'h80000000};
        m_cnt = '0;

        #1;
        check("rst_valid", {31'b0, ov0}, 32'd0);
        check("rst_ready", {31'b0, rdy0}, 32'd0);
        check("rst_word", ib0, 32'h0);
        check("rst_cnt", {16'b0, wc0}, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        check("ready_before_edge", {31'b0, rdy0}, 32'd0);
        tick();
        check("ready_after_rst", {31'b0, rdy0}, 32'd1);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("idle_flush", {31'b0, ov0}, 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_vec(tbl[k]);
            drain(tbl[k]);
        end

        for (int i = 0; i < 17; i++) send_bit(i[0], 1'b0, 1'b0, 32'h0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_word", ib0, 32'h0);
        check("mid_rst_ref", ar0, 32'h0);
        check("mid_rst_ref_neg", am0, 32'h0);
        check("mid_rst_valid", {31'b0, ov0}, 32'd0);
        check("mid_rst_cnt", {16'b0, wc0}, 32'h0);
        check("mid_rst_ready", {31'b0, rdy0}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        m_cnt = '0;
        sbq.delete();
        wv = '{32'hA5A5A5A5, 32, 0, 0, 32'h0, 1'b0, 32'h0, 0,
               32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0};
        run_vec(wv);
        drain(wv);

        force u0.word_cnt = 16'hFFFF;
        force u1.word_cnt = 16'hFFFF;
        #1;
        release u0.word_cnt;
        release u1.word_cnt;
        m_cnt = 16'hFFFF;
        wv = '{32'h00000003, 2, 2, 0, 32'h0, 1'b0, 32'h0, 0,
               32'hC0000000, 32'h00000003, 32'h0, 32'h0};
        run_vec(wv);
        drain(wv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_ref_feeder.md
MOD_REF_FEEDER -- requirements
Module: mod_ref_feeder

Interface
REQ-001 SHALL take parameter MSB_FIRST, default 1, which sets the packing order: 1 means the first bit received lands in bit 31, 0 means it lands in bit 0.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port bit_in, input, 1 bit: serial modulation data bit.
REQ-005 SHALL have port bit_valid, input, 1 bit: bit_in is valid this cycle.
REQ-006 SHALL have port bit_ready, output, 1 bit: the block accepts a bit this cycle.
REQ-007 SHALL have port flush, input, 1 bit: zero-pad and emit a partial word.
REQ-008 SHALL have port ref_in, input, 32 bits: new reference value.
REQ-009 SHALL have port ref_load, input, 1 bit: load ref_in this cycle.
REQ-010 SHALL have port input_bit, output, 32 bits: assembled condition word.
REQ-011 SHALL have port array_ref_wire_1, output, 32 bits: reference operand for the if branch.
REQ-012 SHALL have port array_ref_m_wire_1, output, 32 bits: negated reference operand for the else branch.
REQ-013 SHALL have port out_valid, output, 1 bit: the output triple is valid.
REQ-014 SHALL have port out_ready, input, 1 bit: the downstream if/else stage accepts the output triple.
REQ-015 SHALL have port word_cnt, output, 16 bits: count of words handed off.

Function
REQ-016 SHALL implement an FSM with three states: IDLE (no bits held), SHIFT (1..31 bits held), HOLD (output presented).
REQ-017 SHALL accept a bit when bit_valid and bit_ready are both high; bit_ready is high in IDLE and SHIFT and low in HOLD.
REQ-018 SHALL keep a 5-bit fill counter that increments on each accepted bit.
REQ-019 SHALL pack accepted bits into a 32-bit shift register in the order set by MSB_FIRST.
REQ-020 SHALL move IDLE->SHIFT on the first accepted bit and SHIFT->HOLD on the 32nd, with out_valid high the cycle after the 32nd bit is accepted (1-cycle latency).
REQ-021 SHALL, on flush while in SHIFT, zero-fill the unfilled positions and enter HOLD next cycle.
REQ-022 SHALL, if a bit is accepted in the same cycle as flush, include that bit before padding.
REQ-023 SHALL, if that bit is the 32nd, treat flush as a normal completion.
REQ-024 SHALL ignore flush in IDLE and HOLD.
REQ-025 SHALL keep input_bit, array_ref_wire_1 and array_ref_m_wire_1 stable while out_valid is high until the handshake completes.
REQ-026 SHALL complete the handshake when out_valid and out_ready are both high; that cycle it clears the fill counter, increments word_cnt and moves to IDLE, with bit_ready high the next cycle.
REQ-027 SHALL let word_cnt wrap from 0xFFFF to 0x0000.
REQ-028 SHALL drive array_ref_wire_1 as the reference register captured at HOLD entry.
REQ-029 SHALL drive array_ref_m_wire_1 as (0 - array_ref_wire_1) mod 2^32, so 0x00000000 maps to 0x00000000 and 0x80000000 maps to 0x80000000.
REQ-030 SHALL make ref_load outside HOLD update the reference register next cycle.
REQ-031 SHALL let a ref_load in the same cycle as HOLD entry take effect for the word being entered.
REQ-032 SHALL defer a ref_load during HOLD in a single pending slot (last load wins) and apply it on handshake completion.
REQ-033 SHALL hold input_bit at the last emitted word outside HOLD.

Reset
REQ-034 SHALL, while reset is low, asynchronously force: state IDLE, fill counter 0, shift register 0, reference register 0, pending-load slot empty, word_cnt 0, out_valid 0, and input_bit, array_ref_wire_1, array_ref_m_wire_1 all 0x00000000.
REQ-035 SHALL drive bit_ready low while reset is low and high from the first clock edge after reset deasserts.
REQ-036 SHALL discard any partial word or pending output on reset assertion mid-operation, without emitting it.

Verification
REQ-037 SHALL be covered by a full-word scenario: ref_load 0x00000005, then 32 bits alternating 1,0 with MSB_FIRST=1 -> out_valid high 1 cycle after the last bit, input_bit 0xAAAAAAAA, array_ref_wire_1 0x00000005, array_ref_m_wire_1 0xFFFFFFFB, word_cnt 1 after accept.
REQ-038 SHALL be covered by a backpressure scenario: hold out_ready low 10 cycles after a word completes -> outputs stable, bit_ready low, bit_valid pulses ignored, accept on cycle 11 -> IDLE.
REQ-039 SHALL be covered by a flush scenario: 4 bits 1,1,0,1 then flush with MSB_FIRST=1 -> input_bit 0xD0000000.
REQ-040 SHALL be covered by the flush scenario with MSB_FIRST=0 -> input_bit 0x0000000B.
REQ-041 SHALL be covered by a deferred-load scenario: ref_load 0x80000000 during HOLD with ref 0x00000001 -> current outputs stay 0x00000001 and 0xFFFFFFFF, and the next word shows 0x80000000 and 0x80000000.
REQ-042 SHALL be covered by a reset scenario: assert reset after 17 bits -> all outputs 0 immediately, and the next 32 bits form a fresh word with word_cnt 1.
REQ-043 SHALL be covered by a wrap scenario: preload word_cnt to 0xFFFF via 65535 words (or force), complete one more handshake -> word_cnt 0x0000.
